cache_assoc_controller: RTL

Parametrised N-way set-associative cache controller FSM, the successor to the direct-mapped cache controller. It sits between the pipeline's memory stage and the cache data/tag arrays plus the four-bank main memory. It performs parallel lookup over all ways and picks a victim way by first-invalid, then round-robin. It runs a multi-word write-back and line fill against a fixed-latency memory, and signals hit, done, stall and err to the pipeline.

---
 rtl/cache_assoc_controller.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/cache_assoc_controller.sv
// cache_assoc_controller
//   Control FSM for an N-way set-associative cache. It sits between the
//   pipeline memory stage, the cache data/tag arrays and a fixed-latency
//   main memory. Lookup runs over all ways in parallel. The victim is the
//   lowest invalid way, or the round-robin pointer when the set is full.
//   Misses run an optional multi-word write-back, then an overlapped
//   issue/install line fill.
// Ports
//   clk, rst            clock; synchronous active-low reset
//   global_rd/wr        pipeline request, held until done
//   hit, valid, dirty   per-way lookup results for the indexed set
//   cache_err, mem_err  array / memory fault flags
//   way_sel, comp       way enables and tag-compare mode to the arrays
//   cache_write         cache write strobe
//   cache_offset        word offset into the cache line
//   mem_rd, mem_wr      memory read / write issue
//   mem_offset          word offset of the memory access
//   wb_tag_sel          memory tag comes from the victim (1) or the request (0)
//   stall, done         pipeline handshake (done is a one-cycle pulse)
//   global_hit, err     completion status, valid with done
module cache_assoc_controller #(
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              global_rd,
  input  logic                              global_wr,
  input  logic [NUM_WAYS-1:0]               hit,
  input  logic [NUM_WAYS-1:0]               valid,
  input  logic [NUM_WAYS-1:0]               dirty,
  input  logic                              cache_err,
  input  logic                              mem_err,
  output logic [NUM_WAYS-1:0]               way_sel,
  output logic                              comp,
  output logic                              cache_write,
  output logic [$clog2(WORDS_PER_LINE)-1:0] cache_offset,
  output logic                              mem_rd,
  output logic                              mem_wr,
  output logic [$clog2(WORDS_PER_LINE)-1:0] mem_offset,
  output logic                              wb_tag_sel,
  output logic                              stall,
  output logic                              done,
  output logic                              global_hit,
  output logic                              err
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [2:0]       LAT       = 3'(MEM_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_HIT_DONE, S_WB, S_FILL, S_FINAL, S_MISS_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [WAY_W-1:0]   vp_q, vp_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [OFF_W-1:0]   wc_q, wc_d;
  logic [OFF_W-1:0]   ic_q, ic_d;
  logic               iss_done_q, iss_done_d;
  logic [2:0]         dly_q, dly_d;

  logic [WAY_W-1:0]    victim;
  logic [WAY_W-1:0]    hit_way;
  logic [NUM_WAYS-1:0] way_oh;
  logic                fault;

  // Lowest-index set bit of vec, or fallback when vec is all zero.
  function automatic logic [WAY_W-1:0] first_set(input logic [NUM_WAYS-1:0] vec,
                                                  input logic [WAY_W-1:0]    fallback);
    logic [WAY_W-1:0] sel;
    logic             found;
    sel   = fallback;
    found = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (vec[i] && !found) begin
        sel   = WAY_W'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign victim  = first_set(~valid, vp_q);
  assign hit_way = first_set(hit & valid, '0);
  assign way_oh  = {{(NUM_WAYS-1){1'b0}}, 1'b1} << way_q;
  assign fault   = cache_err | mem_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      vp_q       <= '0;
      way_q      <= '0;
      wc_q       <= '0;
      ic_q       <= '0;
      iss_done_q <= 1'b0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      vp_q       <= vp_d;
      way_q      <= way_d;
      wc_q       <= wc_d;
      ic_q       <= ic_d;
      iss_done_q <= iss_done_d;
      dly_q      <= dly_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vp_d         = vp_q;
    way_d        = way_q;
    wc_d         = wc_q;
    ic_d         = ic_q;
    iss_done_d   = iss_done_q;
    dly_d        = dly_q;
    way_sel      = '0;
    comp         = 1'b0;
    cache_write  = 1'b0;
    cache_offset = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_offset   = '0;
    wb_tag_sel   = 1'b0;
    stall        = 1'b1;
    done         = 1'b0;
    global_hit   = 1'b0;
    err          = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall   = 1'b0;
        comp    = 1'b1;
        way_sel = '1;
        // Requests are ignored while reset is held so no strobe leaks out.
        if (rst && global_rd && global_wr) begin
          state_d = S_ERR;
        end else if (rst && (global_rd || global_wr)) begin
          if (|(hit & valid)) begin
            way_d       = hit_way;
            cache_write = global_wr;
            state_d     = S_HIT_DONE;
          end else begin
            way_d      = victim;
            wc_d       = '0;
            ic_d       = '0;
            iss_done_d = 1'b0;
            dly_d      = '0;
            state_d    = (valid[victim] && dirty[victim]) ? S_WB : S_FILL;
          end
        end
      end
      S_HIT_DONE: begin
        done       = 1'b1;
        global_hit = 1'b1;
        way_sel    = way_oh;
        vp_d       = vp_q + WAY_W'(1);
        state_d    = S_IDLE;
      end
      S_WB: begin
        way_sel      = way_oh;
        cache_offset = wc_q;
        mem_wr       = 1'b1;
        mem_offset   = wc_q;
        wb_tag_sel   = 1'b1;
        if (wc_q == LAST_WORD) begin
          wc_d    = '0;
          state_d = S_FILL;
        end else begin
          wc_d = wc_q + OFF_W'(1);
        end
        if (fault) state_d = S_ERR;
      end
      S_FILL: begin
        // Issue side: one read per cycle until the whole line is requested.
        if (!iss_done_q) begin
          mem_rd     = 1'b1;
          mem_offset = ic_q;
          if (ic_q == LAST_WORD) iss_done_d = 1'b1;
          else                   ic_d       = ic_q + OFF_W'(1);
        end
        // Install side: trails the issue side by the memory latency.
        if (dly_q == LAT) begin
          cache_write  = 1'b1;
          way_sel      = way_oh;
          cache_offset = wc_q;
          if (wc_q == LAST_WORD) begin
            wc_d       = '0;
            ic_d       = '0;
            iss_done_d = 1'b0;
            dly_d      = '0;
            state_d    = S_FINAL;
          end else begin
            wc_d = wc_q + OFF_W'(1);
          end
        end else begin
          dly_d = dly_q + 3'd1;
        end
        if (fault) state_d = S_ERR;
      end
      S_FINAL: begin
        // Re-access the freshly filled line in compare mode; a write merges here.
        comp        = 1'b1;
        way_sel     = way_oh;
        cache_write = global_wr;
        state_d     = fault ? S_ERR : S_MISS_DONE;
      end
      S_MISS_DONE: begin
        done    = 1'b1;
        vp_d    = vp_q + WAY_W'(1);
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
